// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared types, constants and helpers for the Genius key conditioner
package genius_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        RED    = 2'd1,
        YELLOW = 2'd2,
        BLUE   = 2'd3
    } color_t;

    localparam int DEB_CYCLES_DEFAULT = 500000;
    localparam int NUM_KEYS           = 4;

    // Counter must hold 0..n-1; never narrower than one bit.
    function automatic int deb_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [2:0] count_ones4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Lowest key index wins among simultaneous presses.
    function automatic color_t first_key(input logic [3:0] v);
        color_t c;
        c = GREEN;
        if (v[0])      c = GREEN;
        else if (v[1]) c = RED;
        else if (v[2]) c = YELLOW;
        else if (v[3]) c = BLUE;
        return c;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - per-key 2-flop synchroniser, debounce counter and press-edge pulse
module key_debounce
    import genius_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int             CW       = deb_width(DEB_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            stable  <= 1'b1;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            // Raw pins are active-low; level and press are active-high.
            level_q <= ~stable;
            press_q <= ~stable & ~level_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/genius_key_conditioner.sv
// rtl/genius_key_conditioner.sv - four-key debounce, arbitration and event buffer; option KEYCOND_MULTI_ERR_EN
module genius_key_conditioner
    import genius_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic [3:0] KEY,
    input  logic       en,
    output logic       evt_valid,
    output logic [1:0] evt_code,
    input  logic       evt_ready,
    output logic       evt_overrun,
    output logic       err_multi,
    output logic [3:0] key_level
);

    logic [NUM_KEYS-1:0] level;
    logic [NUM_KEYS-1:0] press;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk   (CLOCK_50),
            .rst_n (RST_N),
            .key_n (KEY[i]),
            .level (level[i]),
            .press (press[i])
        );
    end

    logic   any_press;
    logic   multi;
    logic   take;
    color_t sel_code;
    color_t code_q;
    logic   valid_q;
    logic   overrun_q;

    // Levels rise on the same edge as the press pulse, so a key's own
    // press bit is masked out when looking for other held keys.
    always_comb begin
        any_press = |press;
        multi     = (count_ones4(press) >= 3'd2) ||
                    (any_press && (|(level & ~press)));
        sel_code  = first_key(press);
`ifdef KEYCOND_MULTI_ERR_EN
        take      = en && any_press && !multi;
`else
        take      = en && any_press;
`endif
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            valid_q   <= 1'b0;
            code_q    <= GREEN;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (!en) begin
                valid_q <= 1'b0;
            end else if (take) begin
                if (!valid_q || evt_ready) begin
                    valid_q <= 1'b1;
                    code_q  <= sel_code;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (valid_q && evt_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef KEYCOND_MULTI_ERR_EN
    logic err_q;

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= en && multi;
        end
    end

    assign err_multi = err_q;
`else
    assign err_multi = 1'b0;
`endif

    assign evt_valid   = valid_q;
    assign evt_code    = code_q;
    assign evt_overrun = overrun_q;
    assign key_level   = level;

endmodule
